sonic_array: RTL and testbench

Multi-channel ultrasonic ranging controller for the car's obstacle sensing. It drives up to CHANNELS HC-SR04-style sensors in round-robin time slots, one trigger per slot. It measures each echo pulse in microseconds and converts it to centimetres. It also maintains a per-channel "near" flag with hysteresis, which the motor mode logic uses in place of the single fixed `distance < 2` compare.

---
 rtl/sonic_array.sv | 185 ++++++++++++++++++
 tb/tb_sonic_array.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sonic_array.sv
// rtl/sonic_array.sv - round-robin ultrasonic ranging controller with per-channel cm result and near hysteresis
module sonic_array #(
   parameter int CHANNELS    = 4,
   parameter int CLK_HZ      = 100_000_000,
   parameter int TRIG_CYCLES = 1000,
   parameter int SLOT_CYCLES = 6_000_000,
   parameter int TIMEOUT_US  = 25000,
   parameter int DIST_W      = 10,
   parameter int NEAR_CM     = 10,
   parameter int HYST_CM     = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic [CHANNELS-1:0]        echo,
   output logic [CHANNELS-1:0]        trig,
   output logic [CHANNELS*DIST_W-1:0] distance,
   output logic                       valid,
   output logic [2:0]                 valid_ch,
   output logic [CHANNELS-1:0]        timeout,
   output logic [CHANNELS-1:0]        near
);

   localparam int CYC_PER_US = CLK_HZ / 1_000_000;
   localparam int PRE_W      = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
   localparam int SLOT_W     = $clog2(SLOT_CYCLES + 1);
   localparam int TRIG_W     = $clog2(TRIG_CYCLES + 1);
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYC_PER_US - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
   localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
   localparam logic [19:0]       US_LIMIT  = 20'(TIMEOUT_US);
   localparam logic [24:0]       CM_MAX    = 25'((2 ** DIST_W) - 1);
   localparam logic [DIST_W-1:0] NEAR_SET  = DIST_W'(NEAR_CM);
   localparam logic [DIST_W-1:0] NEAR_CLR  = DIST_W'(NEAR_CM + HYST_CM);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_TRIG = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_MEAS = 3'd3;
   localparam logic [2:0] S_CALC = 3'd4;
   localparam logic [2:0] S_GAP  = 3'd5;

   logic [2:0]          state;
   logic [CH_W-1:0]     ch;
   logic [CH_W-1:0]     ch_next;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [TRIG_W-1:0]   trig_cnt;
   logic [CHANNELS-1:0] s1, s2, s_d;
   logic                rise_ch, fall_ch;
   logic [PRE_W-1:0]    pre;
   logic                tick;
   logic [19:0]         us_cnt;
   logic                us_clr;
   logic [19:0]         meas_us;
   logic                meas_to;
   logic [24:0]         prod;
   logic [24:0]         cm_full;
   logic [DIST_W-1:0]   cm;

   // Two flops for metastability, a third to find edges of the synchronised level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1  <= '0;
         s2  <= '0;
         s_d <= '0;
      end else begin
         s1  <= echo;
         s2  <= s1;
         s_d <= s2;
      end
   end

   assign rise_ch = s2[ch] & ~s_d[ch];
   assign fall_ch = ~s2[ch] & s_d[ch];

   assign tick    = (pre == PRE_LAST);
   assign us_clr  = ((state == S_TRIG) && (trig_cnt == TRIG_LAST)) ||
                    ((state == S_WAIT) && rise_ch);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre    <= '0;
         us_cnt <= '0;
      end else if (us_clr) begin
         pre    <= '0;
         us_cnt <= '0;
      end else if (tick) begin
         pre    <= '0;
         us_cnt <= us_cnt + 20'd1;
      end else begin
         pre    <= pre + 1'b1;
      end
   end

   assign prod    = {5'd0, meas_us} * 25'd17;
   assign cm_full = prod / 25'd1000;
   assign cm      = (meas_to || (cm_full > CM_MAX)) ? '1 : cm_full[DIST_W-1:0];
   assign ch_next = (ch == CH_LAST) ? '0 : ch + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ch       <= '0;
         trig     <= '0;
         slot_cnt <= '0;
         trig_cnt <= '0;
         meas_us  <= '0;
         meas_to  <= 1'b0;
         distance <= '0;
         valid    <= 1'b0;
         valid_ch <= 3'd0;
         timeout  <= '0;
         near     <= '0;
      end else begin
         valid <= 1'b0;
         if (state != S_IDLE)
            slot_cnt <= slot_cnt + 1'b1;
         case (state)
            S_IDLE: begin
               if (enable) begin
                  state    <= S_TRIG;
                  trig     <= CHANNELS'(1) << ch;
                  slot_cnt <= '0;
                  trig_cnt <= '0;
               end
            end
            S_TRIG: begin
               trig_cnt <= trig_cnt + 1'b1;
               if (trig_cnt == TRIG_LAST) begin
                  trig  <= '0;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (rise_ch) begin
                  state <= S_MEAS;
               end else if (us_cnt >= US_LIMIT) begin
                  meas_to <= 1'b1;
                  state   <= S_CALC;
               end
            end
            S_MEAS: begin
               // Include the tick landing on this edge so an aligned width reads exact
               if (fall_ch) begin
                  meas_us <= us_cnt + 20'(tick);
                  meas_to <= 1'b0;
                  state   <= S_CALC;
               end else if (us_cnt >= US_LIMIT) begin
                  meas_to <= 1'b1;
                  state   <= S_CALC;
               end
            end
            S_CALC: begin
               distance[ch*DIST_W +: DIST_W] <= cm;
               timeout[ch] <= meas_to;
               if (cm < NEAR_SET)
                  near[ch] <= 1'b1;
               else if (cm >= NEAR_CLR)
                  near[ch] <= 1'b0;
               valid    <= 1'b1;
               valid_ch <= 3'(ch);
               state    <= S_GAP;
            end
            S_GAP: begin
               if (slot_cnt == SLOT_LAST) begin
                  ch <= ch_next;
                  if (enable) begin
                     state    <= S_TRIG;
                     trig     <= CHANNELS'(1) << ch_next;
                     slot_cnt <= '0;
                     trig_cnt <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sonic_array.sv
// tb/tb_sonic_array.sv - scoreboard bench for sonic_array with a behavioural ranging model
module tb_sonic_array;

   localparam int NCH  = 3;
   localparam int DW   = 10;
   localparam int TRIG = 10;
   localparam int SLOT = 5100;
   localparam int TOUT = 2500;
   localparam int NEAR = 10;
   localparam int HYST = 2;

   logic              clk;
   logic              rst_n;
   logic              enable;
   logic [NCH-1:0]    echo;
   logic [NCH-1:0]    trig;
   logic [NCH*DW-1:0] distance;
   logic              valid;
   logic [2:0]        valid_ch;
   logic [NCH-1:0]    timeout;
   logic [NCH-1:0]    near;

   sonic_array #(
      .CHANNELS(NCH), .CLK_HZ(1_000_000), .TRIG_CYCLES(TRIG), .SLOT_CYCLES(SLOT),
      .TIMEOUT_US(TOUT), .DIST_W(DW), .NEAR_CM(NEAR), .HYST_CM(HYST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo), .trig(trig),
      .distance(distance), .valid(valid), .valid_ch(valid_ch),
      .timeout(timeout), .near(near)
   );

   typedef struct {
      int                ch;
      logic [NCH*DW-1:0] dist_vec;
      logic [NCH-1:0]    to_vec;
      logic [NCH-1:0]    near_vec;
      bit                chk_time;
      int                lo;
      int                hi;
   } exp_t;

   exp_t exp_q[$];
   int   compared = 0;
   int   failed = 0;
   int   cyc = 0;
   int   rises = 0;
   int   onehot_viol = 0;
   int   dist_m[NCH];
   bit   to_m[NCH];
   bit   near_m[NCH];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: cm from the echo width in us, hysteretic near, sticky per-channel result
   task automatic model_push(input int ch, input int w, input int tf);
      exp_t e;
      bit   to;
      int   cm;
      to = (w < 0) || (w > TOUT);
      cm = to ? (2 ** DW) - 1 : (w * 17) / 1000;
      if (cm > (2 ** DW) - 1) cm = (2 ** DW) - 1;
      dist_m[ch] = cm;
      to_m[ch]   = to;
      if (cm < NEAR) near_m[ch] = 1'b1;
      else if (cm >= NEAR + HYST) near_m[ch] = 1'b0;
      e.ch = ch;
      for (int k = 0; k < NCH; k++) begin
         e.dist_vec[k*DW +: DW] = DW'(dist_m[k]);
         e.to_vec[k]   = to_m[k];
         e.near_vec[k] = near_m[k];
      end
      e.chk_time = (w < 0);
      e.lo = tf + TOUT;
      e.hi = tf + TOUT + 4;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && valid) begin
         if (exp_q.size() == 0) begin
            compared++;
            failed++;
            $display("FAIL unexpected_valid: valid_ch=%0d with nothing outstanding", valid_ch);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("valid_ch", 64'(valid_ch), 64'(e.ch));
            check("distance", 64'(distance), 64'(e.dist_vec));
            check("timeout", 64'(timeout), 64'(e.to_vec));
            check("near", 64'(near), 64'(e.near_vec));
            if (e.chk_time)
               check("timeout_latency_ok", 64'(cyc >= e.lo && cyc <= e.hi), 64'd1);
         end
      end
   end

   int  exp_ch = 0;
   bit  have_prev = 0;
   int  prev_rise = 0;
   int  rise_cyc = 0;
   logic [NCH-1:0] prev_trig = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_ch    = 0;
         have_prev = 0;
         prev_trig = '0;
      end else begin
         if (!$onehot0(trig)) onehot_viol++;
         if (trig != '0 && prev_trig == '0) begin
            rises++;
            check("trig_channel", 64'(trig), 64'(1) << exp_ch);
            if (have_prev) check("slot_period", 64'(cyc - prev_rise), 64'(SLOT));
            prev_rise = cyc;
            rise_cyc  = cyc;
            have_prev = 1;
            exp_ch    = (exp_ch + 1) % NCH;
         end
         if (trig == '0 && prev_trig != '0)
            check("trig_width", 64'(cyc - rise_cyc), 64'(TRIG));
         prev_trig = trig;
      end
   end

   task automatic wait_trig(input int ch, input logic lvl, input int lim, input string nm);
      int n;
      n = 0;
      while (trig[ch] !== lvl && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (trig[ch] !== lvl) begin
         compared++;
         failed++;
         $display("FAIL %s: trig[%0d] never reached %0d within %0d cycles", nm, ch, lvl, lim);
      end
   endtask

   task automatic do_slot(input int ch, input int w, input bit pre, input bit drop_en);
      int o;
      int d;
      int tf;
      o = (ch + 1) % NCH;
      wait_trig(ch, 1'b1, 2 * SLOT, "trig_rise");
      if (pre) begin
         @(negedge clk);
         echo[ch] = 1'b1;
      end
      wait_trig(ch, 1'b0, TRIG + 4, "trig_fall");
      tf = cyc;
      if (drop_en) enable = 1'b0;
      @(negedge clk); echo[o] = 1'b1;
      @(negedge clk); echo[o] = 1'b0;
      if (pre) begin
         repeat (30) @(negedge clk);
         echo[ch] = 1'b0;
         repeat (10) @(negedge clk);
      end
      d = $urandom_range(5, 150);
      model_push(ch, w, tf);
      if (w < 0) begin
         repeat (TOUT + 20) @(negedge clk);
         return;
      end
      repeat (d) @(negedge clk);
      echo[ch] = 1'b1;
      for (int i = 0; i < w; i++) begin
         @(negedge clk);
         if (i == 2) echo[o] = 1'b1;
         if (i == 4) echo[o] = 1'b0;
      end
      echo[ch] = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   int w_tab[9] = '{530, 530, -1, 0, 648, 2000, 0, 706, 2600};

   initial begin
      int w;
      int r0;
      int n;
      rst_n  = 1'b0;
      enable = 1'b0;
      echo   = '0;
      for (int k = 0; k < NCH; k++) begin dist_m[k] = 0; to_m[k] = 0; near_m[k] = 0; end
      repeat (3) @(negedge clk);
      check("rst_trig", 64'(trig), 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_valid_ch", 64'(valid_ch), 64'd0);
      check("rst_distance", 64'(distance), 64'd0);
      check("rst_timeout", 64'(timeout), 64'd0);
      check("rst_near", 64'(near), 64'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_no_trig", 64'(rises), 64'd0);
      enable = 1'b1;

      for (int s = 0; s < 9; s++) begin
         w = w_tab[s];
         if (w == 0) w = $urandom_range(550, 2400);
         do_slot(s % NCH, w, s == 6, 1'b0);
      end

      wait_trig(0, 1'b1, 2 * SLOT, "trig_rise");
      wait_trig(0, 1'b0, TRIG + 4, "trig_fall");
      repeat (20) @(negedge clk);
      echo[0] = 1'b1;
      repeat (100) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_trig", 64'(trig), 64'd0);
      check("midreset_valid", 64'(valid), 64'd0);
      check("midreset_distance", 64'(distance), 64'd0);
      check("midreset_timeout", 64'(timeout), 64'd0);
      check("midreset_near", 64'(near), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      echo[0] = 1'b0;
      for (int k = 0; k < NCH; k++) begin dist_m[k] = 0; to_m[k] = 0; near_m[k] = 0; end
      rst_n = 1'b1;

      do_slot(0, $urandom_range(100, 2400), 1'b0, 1'b1);
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      r0 = rises;
      repeat (SLOT + 200) @(negedge clk);
      check("idle_after_disable", 64'(rises), 64'(r0));
      check("trig_onehot", 64'(onehot_viol), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

   initial begin
      #900_000;
      compared++;
      failed++;
      $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
